// File: rtl/bullet_sprite_renderer_pkg.sv
// Shared definitions for the bullet sprite renderer: screen geometry,
// palette constants and the renderer state encoding.
package bullet_sprite_renderer_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } render_state_t;

endpackage

// File: rtl/bullet_sprite_renderer_if.sv
// Plot-port bundle between a drawer and the draw-side arbiter / VGA adapter.
interface bullet_sprite_renderer_if;

  logic       draw_req;
  logic       draw_grant;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output draw_req,
    output vga_x,
    output vga_y,
    output vga_colour,
    output vga_plot,
    input  draw_grant
  );

  modport slave (
    input  draw_req,
    input  vga_x,
    input  vga_y,
    input  vga_colour,
    input  vga_plot,
    output draw_grant
  );

endinterface

// File: rtl/bullet_sprite_renderer_rect_scanner.sv
// Row-major walk over a SPRITE_W x SPRITE_H rectangle anchored at base_x/base_y;
// steps one pixel per advance and wraps back to the origin after the last one.
module rect_scanner #(
  parameter int SPRITE_W      = 8,
  parameter int SPRITE_H      = 3,
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       advance,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  output logic [8:0] px,
  output logic [7:0] py,
  output logic       in_bounds,
  output logic       last
);

  localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  logic [CXW-1:0] cx_reg;
  logic [CYW-1:0] cy_reg;
  logic           last_col;

  assign last_col  = (cx_reg == CXW'(SPRITE_W - 1));
  assign last      = last_col && (cy_reg == CYW'(SPRITE_H - 1));

  // Sums are one bit wider than the screen coordinates so off-screen pixels are detectable.
  assign px        = {1'b0, base_x} + 9'(cx_reg);
  assign py        = {1'b0, base_y} + 8'(cy_reg);
  assign in_bounds = (px < 9'(SCREEN_WIDTH)) && (py < 8'(SCREEN_HEIGHT));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (start) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (advance) begin
      if (last_col) begin
        cx_reg <= '0;
        cy_reg <= last ? '0 : cy_reg + CYW'(1);
      end else begin
        cx_reg <= cx_reg + CXW'(1);
      end
    end
  end

endmodule

// File: rtl/bullet_sprite_renderer.sv
// Redraws one bullet sprite whenever its position or visibility changes:
// erase the old rectangle, draw the new one, one pixel per granted cycle.
module bullet_sprite_renderer #(
  parameter int         SPRITE_W      = 8,
  parameter int         SPRITE_H      = 3,
  parameter int         SCREEN_WIDTH  = bullet_sprite_renderer_pkg::SCREEN_WIDTH,
  parameter int         SCREEN_HEIGHT = bullet_sprite_renderer_pkg::SCREEN_HEIGHT,
  parameter logic [2:0] ERASE_COLOR   = bullet_sprite_renderer_pkg::COL_BLACK
) (
  input  logic                            CLOCK_50,
  input  logic                            resetn,
  input  logic                            enable,
  input  logic [7:0]                      bullet_x,
  input  logic [6:0]                      bullet_y,
  input  logic                            bullet_active,
  input  logic [2:0]                      bullet_color,
  output logic                            busy,
  output logic                            frame_done,
  bullet_sprite_renderer_if.master        draw_bus
);

  import bullet_sprite_renderer_pkg::*;

  render_state_t state_reg, state_next;

  logic [7:0] shown_x_reg, tgt_x_reg;
  logic [6:0] shown_y_reg, tgt_y_reg;
  logic       shown_valid_reg, tgt_valid_reg;
  logic [2:0] tgt_col_reg;

  logic       draw_req_reg, draw_req_next;
  logic       plot_reg, plot_next;
  logic       frame_done_reg, frame_done_next;
  logic       busy_reg;
  logic [7:0] x_reg;
  logic [6:0] y_reg;
  logic [2:0] colour_reg, pix_colour;

  logic       change, latch_tgt, commit, scan_start, scan_advance;
  logic [8:0] px;
  logic [7:0] py;
  logic       in_bounds, scan_last;

  // Colour alone never triggers a redraw; only position or visibility do.
  assign change = (bullet_active != shown_valid_reg) ||
                  (bullet_active && ((bullet_x != shown_x_reg) || (bullet_y != shown_y_reg)));

  assign pix_colour = (state_reg == ST_ERASE) ? ERASE_COLOR : tgt_col_reg;

  rect_scanner #(
    .SPRITE_W      (SPRITE_W),
    .SPRITE_H      (SPRITE_H),
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT)
  ) u_scan (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .start     (scan_start),
    .advance   (scan_advance),
    .base_x    ((state_reg == ST_ERASE) ? shown_x_reg : tgt_x_reg),
    .base_y    ((state_reg == ST_ERASE) ? shown_y_reg : tgt_y_reg),
    .px        (px),
    .py        (py),
    .in_bounds (in_bounds),
    .last      (scan_last)
  );

  always_comb begin
    state_next      = state_reg;
    latch_tgt       = 1'b0;
    commit          = 1'b0;
    scan_start      = 1'b0;
    scan_advance    = 1'b0;
    draw_req_next   = draw_req_reg;
    plot_next       = 1'b0;
    frame_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable && change) begin
          latch_tgt     = 1'b1;
          draw_req_next = 1'b1;
          state_next    = ST_REQ;
        end
      end
      ST_REQ: begin
        scan_start = 1'b1;
        if (draw_bus.draw_grant) begin
          if (shown_valid_reg)    state_next = ST_ERASE;
          else if (tgt_valid_reg) state_next = ST_DRAW;
          else                    state_next = ST_DONE;
        end
      end
      ST_ERASE, ST_DRAW: begin
        // Without a grant the scanner holds, so the same pixel is retried next cycle.
        if (draw_bus.draw_grant) begin
          scan_advance = 1'b1;
          plot_next    = in_bounds && !px[8] && !py[7];
          if (scan_last) begin
            if (state_reg == ST_ERASE && tgt_valid_reg) state_next = ST_DRAW;
            else                                        state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        commit          = 1'b1;
        draw_req_next   = 1'b0;
        frame_done_next = 1'b1;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      shown_x_reg     <= '0;
      shown_y_reg     <= '0;
      shown_valid_reg <= 1'b0;
      tgt_x_reg       <= '0;
      tgt_y_reg       <= '0;
      tgt_valid_reg   <= 1'b0;
      tgt_col_reg     <= '0;
      draw_req_reg    <= 1'b0;
      plot_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      colour_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      draw_req_reg   <= draw_req_next;
      plot_reg       <= plot_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= (state_next != ST_IDLE);
      if (latch_tgt) begin
        tgt_x_reg     <= bullet_x;
        tgt_y_reg     <= bullet_y;
        tgt_valid_reg <= bullet_active;
        tgt_col_reg   <= bullet_color;
      end
      if (scan_advance) begin
        x_reg      <= px[7:0];
        y_reg      <= py[6:0];
        colour_reg <= pix_colour;
      end
      if (commit) begin
        shown_x_reg     <= tgt_x_reg;
        shown_y_reg     <= tgt_y_reg;
        shown_valid_reg <= tgt_valid_reg;
      end
    end
  end

  assign draw_bus.draw_req   = draw_req_reg;
  assign draw_bus.vga_x      = x_reg;
  assign draw_bus.vga_y      = y_reg;
  assign draw_bus.vga_colour = colour_reg;
  assign draw_bus.vga_plot   = plot_reg;
  assign busy                = busy_reg;
  assign frame_done          = frame_done_reg;

endmodule

// File: tb/tb_bullet_sprite_renderer.sv
// Directed and random updates of the bullet sprite renderer, checked against
// a pixel-list model of what each erase/draw should put on screen.
module tb_bullet_sprite_renderer;

  localparam int W  = 8;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int SW = 160;
  localparam int SH = 120;
  localparam logic [2:0] ERASE_COL = 3'b000;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] bullet_x = '0;
  logic [6:0] bullet_y = '0;
  logic       bullet_active = 1'b0;
  logic [2:0] bullet_color = '0;
  logic       busy, frame_done;

  bullet_sprite_renderer_if draw_if ();

  bullet_sprite_renderer dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .enable        (enable),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .bullet_color  (bullet_color),
    .busy          (busy),
    .frame_done    (frame_done),
    .draw_bus      (draw_if.master)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int   checks = 0;
  int   errors = 0;
  pix_t obs_q[$];
  pix_t exp_q[$];
  int   busy_total = 0;
  int   fd_total = 0;

  // Model of what is on screen
  int   m_sx = 0;
  int   m_sy = 0;
  bit   m_sv = 1'b0;

  always @(negedge CLOCK_50) begin
    if (draw_if.vga_plot) obs_q.push_back({draw_if.vga_x, draw_if.vga_y, draw_if.vga_colour});
    if (busy) busy_total++;
    if (frame_done) fd_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic add_rect(input int bx, input int by, input logic [2:0] c);
    for (int cy = 0; cy < H; cy++)
      for (int cx = 0; cx < W; cx++)
        if (bx + cx < SW && by + cy < SH)
          exp_q.push_back({8'(bx + cx), 7'(by + cy), c});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":req"}, draw_if.draw_req, 0);
    check({tag, ":plot"}, draw_if.vga_plot, 0);
    check({tag, ":x"}, draw_if.vga_x, 0);
    check({tag, ":y"}, draw_if.vga_y, 0);
    check({tag, ":col"}, draw_if.vga_colour, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":fd"}, frame_done, 0);
  endtask

  task automatic compare_pixels(input string tag, input int base);
    check({tag, ":npix"}, obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
      check($sformatf("%s:pix%0d", tag, i), obs_q[base + i], exp_q[i]);
  endtask

  // One update request; the inputs are driven now and the whole update is followed to completion.
  task automatic update(input int x, input int y, input bit act, input logic [2:0] c,
                        input bit rnd_grant, input string tag);
    bit chg;
    bit first_vis;
    int phases, base_obs, base_busy, base_fd, t;
    chg = (act != m_sv) || (act && (x != m_sx || y != m_sy));
    exp_q.delete();
    phases = 0;
    if (chg && m_sv) begin add_rect(m_sx, m_sy, ERASE_COL); phases++; end
    if (chg && act)  begin add_rect(x, y, c); phases++; end
    first_vis = m_sv ? (m_sx < SW && m_sy < SH) : (x < SW && y < SH);
    enable = 1'b1;
    bullet_x = 8'(x);
    bullet_y = 7'(y);
    bullet_active = act;
    bullet_color = c;
    base_obs = obs_q.size();
    base_busy = busy_total;
    base_fd = fd_total;
    tick();
    t = 1;
    check({tag, ":req_n+1"}, draw_if.draw_req, chg);
    if (!chg) begin
      repeat (4) tick();
      check({tag, ":idle_busy"}, busy, 0);
      check({tag, ":idle_npix"}, obs_q.size() - base_obs, 0);
      return;
    end
    while (!frame_done && t < 600) begin
      if (rnd_grant) draw_if.draw_grant = ($urandom_range(0, 3) != 0);
      tick();
      t++;
      if (!rnd_grant && t == 3) check({tag, ":first_pix_n+3"}, draw_if.vga_plot, first_vis);
    end
    draw_if.draw_grant = 1'b1;
    check({tag, ":done_seen"}, frame_done, 1);
    check({tag, ":done_req"}, draw_if.draw_req, 0);
    check({tag, ":done_busy"}, busy, 0);
    if (!rnd_grant) begin
      check({tag, ":done_cycle"}, t, 3 + N * phases);
      check({tag, ":busy_cycles"}, busy_total - base_busy, N * phases + 2);
    end
    tick();
    check({tag, ":fd_pulse"}, fd_total - base_fd, 1);
    compare_pixels(tag, base_obs);
    m_sx = x;
    m_sy = y;
    m_sv = act;
  endtask

  initial begin
    int rises, base, t;
    draw_if.draw_grant = 1'b1;

    // Reset and quiet idle
    repeat (3) tick();
    check_all_zero("reset");
    resetn = 1'b1;
    enable = 1'b1;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (draw_if.draw_req) rises++;
    end
    check("idle_no_req", rises, 0);

    update(0, 71, 1'b1, 3'b001, 1'b0, "appear");
    update(1, 71, 1'b1, 3'b001, 1'b0, "move");
    update(1, 71, 1'b1, 3'b110, 1'b0, "colour_only");

    // enable low blocks a pending change
    enable = 1'b0;
    bullet_x = 8'd30;
    bullet_y = 7'd10;
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (draw_if.draw_req) rises++;
    end
    check("enable_low_no_req", rises, 0);
    update(30, 10, 1'b1, 3'b001, 1'b0, "enable_rise");

    update(156, 61, 1'b1, 3'b111, 1'b0, "clip_right");
    update(20, 91, 1'b1, 3'b010, 1'b0, "pre_deact");
    update(20, 91, 1'b0, 3'b010, 1'b0, "deact");
    update(150, 118, 1'b1, 3'b101, 1'b0, "clip_corner");

    for (int i = 0; i < 10; i++) begin
      int rx, ry;
      rx = ($urandom_range(0, 9) == 0) ? m_sx : int'($urandom_range(0, 175));
      ry = ($urandom_range(0, 9) == 0) ? m_sy : int'($urandom_range(0, 127));
      update(rx, ry, ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), 1'(i % 2),
             $sformatf("rand%0d", i));
    end

    // Grant withdrawn for five cycles at draw pixel 10
    if (m_sv) update(m_sx, m_sy, 1'b0, 3'b000, 1'b0, "gl_clear");
    bullet_x = 8'd40;
    bullet_y = 7'd50;
    bullet_color = 3'b011;
    bullet_active = 1'b1;
    base = obs_q.size();
    t = 0;
    while (obs_q.size() - base < 10 && t < 100) begin
      tick();
      t++;
    end
    check("gl_reach10", obs_q.size() - base, 10);
    draw_if.draw_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("gl_hold%0d", i), draw_if.vga_plot, 0);
    end
    draw_if.draw_grant = 1'b1;
    tick();
    check("gl_resume_plot", draw_if.vga_plot, 1);
    check("gl_resume_x", draw_if.vga_x, 42);
    check("gl_resume_y", draw_if.vga_y, 51);
    t = 0;
    while (!frame_done && t < 100) begin
      tick();
      t++;
    end
    check("gl_done", frame_done, 1);
    exp_q.delete();
    add_rect(40, 50, 3'b011);
    compare_pixels("gl", base);
    m_sx = 40;
    m_sy = 50;
    m_sv = 1'b1;
    tick();

    // Reset while erasing
    bullet_x = 8'd60;
    bullet_y = 7'd30;
    base = obs_q.size();
    t = 0;
    while (obs_q.size() - base < 5 && t < 100) begin
      tick();
      t++;
    end
    check("rst_mid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick();
    check_all_zero("rst_held");
    m_sx = 0;
    m_sy = 0;
    m_sv = 1'b0;
    resetn = 1'b1;
    update(60, 30, 1'b1, 3'b011, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_sprite_renderer.md
Name: bullet_sprite_renderer

Overview:
- Downstream consumer of the horizontal/vertical bullet generators.
- Watches one bullet's position, active flag and colour. Whenever these change, it erases the old sprite rectangle and draws the new one through the shared VGA adapter plot interface, one pixel per clock.
- Shares the adapter with other drawers through a req/grant handshake. The draw-side arbiter sits between this block and the VGA adapter.

Parameters:
- SPRITE_W, 8, sprite width in pixels.
- SPRITE_H, 3, sprite height in pixels.
- SCREEN_WIDTH, 160, visible x range is 0..159.
- SCREEN_HEIGHT, 120, visible y range is 0..119.
- ERASE_COLOR, 3'b000, background colour used for erasing.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  allows new update requests to start.
- bullet_x  in  8  bullet top-left x.
- bullet_y  in  7  bullet top-left y.
- bullet_active  in  1  bullet is visible.
- bullet_color  in  3  sprite colour.
- draw_grant  in  1  arbiter grants plot port; may drop at any time.
- draw_req  out  1  request for the plot port.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe, one pixel per cycle.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when an update completes.

Behaviour:
- Reset state: all outputs are registered and reset to 0. State is IDLE. shown_valid=0, shown_x=0, shown_y=0. The screen is assumed cleared externally.
- Tracked registers:
  - shown_x, shown_y, shown_valid: what is currently on screen.
  - tgt_x, tgt_y, tgt_col, tgt_valid: latched target.
- Change condition: (bullet_active != shown_valid) OR (bullet_active AND (bullet_x != shown_x OR bullet_y != shown_y)).
  - A colour-only change does not trigger an update.
- IDLE:
  - If enable AND change: latch tgt_* from the inputs, go to REQ, and set draw_req=1 on the next edge.
  - If enable=0: no new update starts.
- REQ:
  - draw_req=1.
  - On a cycle where draw_grant=1, go to ERASE if shown_valid, else to DRAW if tgt_valid, else to DONE.
- ERASE:
  - Scan cx 0..SPRITE_W-1 (inner) and cy 0..SPRITE_H-1 (outer).
  - Each granted cycle outputs vga_x=shown_x+cx, vga_y=shown_y+cy, vga_colour=ERASE_COLOR, vga_plot=1.
  - After the last pixel, go to DRAW if tgt_valid, else to DONE.
- DRAW:
  - Same scan at tgt_x/tgt_y, colour tgt_col.
  - After the last pixel, go to DONE.
- DONE:
  - shown_* <= tgt_*; draw_req=0; frame_done=1 for one cycle; vga_plot=0; return to IDLE.
- Clipping:
  - Sums are computed 9 bits wide (x) and 8 bits wide (y).
  - A pixel with sum x >= SCREEN_WIDTH or sum y >= SCREEN_HEIGHT gives vga_plot=0, but the scan still advances by one cycle.
- Grant loss:
  - draw_req stays high from REQ through the last pixel.
  - In a cycle with draw_grant=0 during ERASE or DRAW: vga_plot=0 and the scan counters hold. The scan resumes at exactly the same pixel.
- Latency:
  - Input change in cycle n gives draw_req=1 in n+1.
  - With grant tied high, the first pixel is in n+3.
  - An update takes SPRITE_W*SPRITE_H cycles per phase, plus 1 cycle for DONE.
- Inputs during an update: changes to the inputs while busy are ignored because the target is latched. They are re-evaluated in the first IDLE cycle after DONE.
- enable dropped mid-update: the update completes normally.
- Reset mid-operation: immediate return to IDLE with reset values. A partial sprite may remain on screen; the screen clear is the top level's job.

Decomposition:
- Shared package holds:
  - SCREEN_WIDTH/SCREEN_HEIGHT constants.
  - Colour constants: COL_BLACK=3'b000, COL_BLUE=3'b001, COL_WHITE=3'b111.
  - Renderer state encoding: IDLE, REQ, ERASE, DRAW, DONE.
- One sub-module, rect_scanner:
  - Inputs: start, advance, base x/y.
  - Outputs: pixel x/y (9-bit and 8-bit), in_bounds, last.
  - Holds when advance=0.
  - Instantiated once and reused by ERASE and DRAW.

Test Plan:
1. Reset -> all outputs 0 and busy=0; with bullet_active=0 steady, draw_req never rises.
2. Appearance, grant tied 1. Bullet appears at (0,71), colour 3'b001 ->
   - no erase;
   - 24 plots at x 0..7, y 71..73, colour 001, row-major;
   - frame_done pulses once.
3. Move. Bullet moves (0,71)->(1,71) ->
   - 24 erase plots, colour 000, at x 0..7;
   - then 24 draw plots at x 1..8;
   - 49 busy cycles after REQ.
4. Right-edge clipping. Bullet at (156,61) ->
   - only x 156..159 plotted (12 plots);
   - 12 suppressed cycles;
   - total scan length still 24 cycles.
5. Deactivation. bullet_active 1->0 with shown at (20,91) ->
   - 24 erase plots only, no draw;
   - shown_valid=0 after DONE.
6. Grant loss and reset.
   - Drop draw_grant for 5 cycles at DRAW pixel 10 -> vga_plot=0 for 5 cycles; pixel 10 is emitted when grant returns.
   - Separately, pulse resetn low mid-ERASE -> IDLE immediately, all outputs 0.
